gemm_tile_controller: RTL and testbench

GEMM_TILE_CONTROLLER -- requirements
Module: gemm_tile_controller

---
 rtl/gemm_tile_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_gemm_tile_controller.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_controller.sv
// gemm_tile_controller: sequences the M/N/K tile loops of a GEMM and hands out output-tile results.
// Latency: start to first beat is 1 cycle; last-K beat to result_valid_o is 1 cycle; final acceptance to done_o is 1 cycle.
// Backpressure: a result held by result_ready_i = 0 stalls operand intake (input_ready_o drops combinationally).
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   start_i, mode_i                 run request and loop order (0: M/N/K, 1: N/M/K), latched at start
//   M_size_i, K_size_i, N_size_i    loop bounds in tiles, latched at start
//   input_valid_i / input_ready_o   operand beat handshake
//   result_valid_o / result_ready_i output-tile result handshake
//   acc_clear_o                     current beat opens a new output tile (K index 0)
//   M_count_o, K_count_o, N_count_o current loop indices
//   result_m_o, result_n_o          coordinates of the pending result
//   busy_o, done_o, err_o           run in progress, run-finished pulse, zero-size start pulse
//   cycle_cnt_o, stall_cnt_o        performance counters, present only when GEMM_CTRL_PERF_CNT_EN is defined
//
// Build option: define GEMM_CTRL_PERF_CNT_EN to add the saturating cycle/stall counters.

module gemm_tile_controller #(
  parameter int AddrWidth  = 16,
  parameter int CountWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [AddrWidth-1:0]  M_size_i,
  input  logic [AddrWidth-1:0]  K_size_i,
  input  logic [AddrWidth-1:0]  N_size_i,
  input  logic                  input_valid_i,
  output logic                  input_ready_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  acc_clear_o,
  output logic [AddrWidth-1:0]  M_count_o,
  output logic [AddrWidth-1:0]  K_count_o,
  output logic [AddrWidth-1:0]  N_count_o,
  output logic [AddrWidth-1:0]  result_m_o,
  output logic [AddrWidth-1:0]  result_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
`ifdef GEMM_CTRL_PERF_CNT_EN
  ,
  output logic [CountWidth-1:0] cycle_cnt_o,
  output logic [CountWidth-1:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);

  state_t               state;
  logic                 loop_mode;
  logic [AddrWidth-1:0] m_size;
  logic [AddrWidth-1:0] k_size;
  logic [AddrWidth-1:0] n_size;

  logic                 sizes_ok;
  logic                 start_ok;
  logic                 beat;
  logic                 result_take;
  logic                 k_last;
  logic                 m_last;
  logic                 n_last;
  logic                 final_beat;
  logic [AddrWidth-1:0] m_next;
  logic [AddrWidth-1:0] k_next;
  logic [AddrWidth-1:0] n_next;

  assign sizes_ok    = (M_size_i != '0) && (K_size_i != '0) && (N_size_i != '0);
  assign start_ok    = (state == IDLE) && start_i && sizes_ok;
  assign result_take = result_valid_o && result_ready_i;

  // Intake may continue while a result is pending as long as that result is
  // being accepted this cycle: the slot frees at the same edge a new result
  // could land in it, so no gap cycle is needed.
  assign input_ready_o = (state == BUSY) && !(result_valid_o && !result_ready_i);
  assign beat          = input_valid_i && input_ready_o;

  // Index comparisons against the latched bounds. Outside BUSY the bounds may
  // be zero (wrapping to all-ones), but these terms are only consumed on a beat.
  assign k_last     = (K_count_o == k_size - AddrOne);
  assign m_last     = (M_count_o == m_size - AddrOne);
  assign n_last     = (N_count_o == n_size - AddrOne);
  assign final_beat = beat && k_last && m_last && n_last;

  // Asserted whenever intake is open at K index 0, whether or not a beat
  // actually arrives, so the datapath can qualify it with its own valid.
  assign acc_clear_o = (state == BUSY) && input_ready_o && (K_count_o == '0);

  // Next loop indices for a beat. K is always innermost; mode selects whether
  // N (mode 0) or M (mode 1) is the middle loop. After the final beat every
  // index wraps to zero, which leaves the counters cleared for DRAIN.
  always_comb begin
    m_next = M_count_o;
    k_next = K_count_o;
    n_next = N_count_o;
    if (!k_last) begin
      k_next = K_count_o + AddrOne;
    end else begin
      k_next = '0;
      if (!loop_mode) begin
        if (!n_last) begin
          n_next = N_count_o + AddrOne;
        end else begin
          n_next = '0;
          m_next = m_last ? '0 : M_count_o + AddrOne;
        end
      end else begin
        if (!m_last) begin
          m_next = M_count_o + AddrOne;
        end else begin
          m_next = '0;
          n_next = n_last ? '0 : N_count_o + AddrOne;
        end
      end
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      loop_mode      <= 1'b0;
      m_size         <= '0;
      k_size         <= '0;
      n_size         <= '0;
      M_count_o      <= '0;
      K_count_o      <= '0;
      N_count_o      <= '0;
      result_valid_o <= 1'b0;
      result_m_o     <= '0;
      result_n_o     <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (sizes_ok) begin
              loop_mode <= mode_i;
              m_size    <= M_size_i;
              k_size    <= K_size_i;
              n_size    <= N_size_i;
              M_count_o <= '0;
              K_count_o <= '0;
              N_count_o <= '0;
              busy_o    <= 1'b1;
              state     <= BUSY;
            end else begin
              err_o <= 1'b1;
            end
          end
        end

        BUSY: begin
          if (beat) begin
            M_count_o <= m_next;
            K_count_o <= k_next;
            N_count_o <= n_next;
          end
          // A new last-K beat overwrites a result accepted this same cycle.
          if (beat && k_last) begin
            result_valid_o <= 1'b1;
            result_m_o     <= M_count_o;
            result_n_o     <= N_count_o;
          end else if (result_take) begin
            result_valid_o <= 1'b0;
          end
          if (final_beat) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          if (result_take) begin
            result_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b1;
            state          <= DONE;
          end
        end

        DONE: begin
          M_count_o <= '0;
          K_count_o <= '0;
          N_count_o <= '0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GEMM_CTRL_PERF_CNT_EN
  // Saturating counters: active cycles of a run, and cycles where the
  // producer offered a beat that the controller could not take.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else if (start_ok) begin
      cycle_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if ((state == BUSY || state == DRAIN) && (cycle_cnt_o != '1)) begin
        cycle_cnt_o <= cycle_cnt_o + CountWidth'(1);
      end
      if ((state == BUSY) && input_valid_i && !input_ready_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CountWidth'(1);
      end
    end
  end
`else
  // Counter width has no consumer in this build.
  logic [CountWidth-1:0] unused_count_width;
  assign unused_count_width = '0;
`endif

endmodule

// File: tb/tb_gemm_tile_controller.sv
module tb_gemm_tile_controller;
  localparam int AW    = 16;
  localparam int CW    = 32;
  localparam int LIMIT = 1500;
  localparam int NT    = 17;
  localparam int NRUNS = 30;

  logic          clk = 1'b0;
  logic          rst, start, mode, iv, ir, rv, rr, ac, busy, done, err;
  logic [AW-1:0] ms, ks, ns, mc, kc, nc, rm, rn;
`ifdef GEMM_CTRL_PERF_CNT_EN
  logic [CW-1:0] cyc_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  gemm_tile_controller #(.AddrWidth(AW), .CountWidth(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .mode_i        (mode),
    .M_size_i      (ms),
    .K_size_i      (ks),
    .N_size_i      (ns),
    .input_valid_i (iv),
    .input_ready_o (ir),
    .result_valid_o(rv),
    .result_ready_i(rr),
    .acc_clear_o   (ac),
    .M_count_o     (mc),
    .K_count_o     (kc),
    .N_count_o     (nc),
    .result_m_o    (rm),
    .result_n_o    (rn),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
`ifdef GEMM_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt_o   (cyc_cnt),
    .stall_cnt_o   (stall_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic md, input int m_s, input int k_s,
                       input int n_s, input logic v, input logic r);
    start = st;
    mode  = md;
    ms    = AW'(m_s);
    ks    = AW'(k_s);
    ns    = AW'(n_s);
    iv    = v;
    rr    = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " busy"},   64'(busy), 64'd0);
    chk({tag, " done"},   64'(done), 64'd0);
    chk({tag, " err"},    64'(err),  64'd0);
    chk({tag, " ready"},  64'(ir),   64'd0);
    chk({tag, " rvalid"}, 64'(rv),   64'd0);
    chk({tag, " aclr"},   64'(ac),   64'd0);
    chk({tag, " mcnt"},   64'(mc),   64'd0);
    chk({tag, " kcnt"},   64'(kc),   64'd0);
    chk({tag, " ncnt"},   64'(nc),   64'd0);
    chk({tag, " rm"},     64'(rm),   64'd0);
    chk({tag, " rn"},     64'(rn),   64'd0);
  endtask

  // Directed 2x3x2 run checkpoints, valid and ready held high, start at cycle 0.
  typedef struct {
    int mode, cyc, busy, ir, ac, rv, rm, rn, done, mc, kc, nc;
  } vec_t;
  vec_t tbl[NT];

  // Reference model: loop order as a plain list of (m,k,n) beats.
  typedef struct {int m, k, n;} beat_t;
  beat_t bq[$];

  task automatic build_order(input int m_s, input int k_s, input int n_s, input logic md);
    bq.delete();
    if (!md) begin
      for (int m = 0; m < m_s; m++)
        for (int n = 0; n < n_s; n++)
          for (int k = 0; k < k_s; k++) bq.push_back('{m, k, n});
    end else begin
      for (int n = 0; n < n_s; n++)
        for (int m = 0; m < m_s; m++)
          for (int k = 0; k < k_s; k++) bq.push_back('{m, k, n});
    end
  endtask

  task automatic rand_run(input int r);
    int   m_s, k_s, n_s, phase, bi, pm, pn, ecyc, estall, total;
    logic md, pend, eerr, eerr_n, act, e_ir, e_ac, beat, taken, good, finished;
    string tag;
    m_s = $urandom_range(1, 4);
    k_s = $urandom_range(1, 4);
    n_s = $urandom_range(1, 4);
    md  = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 2))
        0: m_s = 0;
        1: k_s = 0;
        default: n_s = 0;
      endcase
    end
    good = (m_s != 0) && (k_s != 0) && (n_s != 0);
    phase = 0; bi = 0; pm = 0; pn = 0; pend = 0; eerr = 0;
    ecyc = 0; estall = 0; total = 0; finished = 0;
    for (int c = 0; c < LIMIT; c++) begin
      if (c == 0) drive(1'b1, md, m_s, k_s, n_s, 1'b0, 1'b0);
      else drive((phase != 0) && ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 1'b0, 1'b0);
      iv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      tag  = $sformatf("rand%0d c%0d", r, c);
      act  = (phase == 1) && (bi < total);
      e_ir = act && !(pend && !rr);
      e_ac = e_ir && (bq[bi].k == 0);
      chk({tag, " ready"},  64'(ir),   64'(e_ir));
      chk({tag, " aclr"},   64'(ac),   64'(e_ac));
      chk({tag, " rvalid"}, 64'(rv),   64'(pend));
      chk({tag, " busy"},   64'(busy), 64'(phase == 1));
      chk({tag, " done"},   64'(done), 64'(phase == 2));
      chk({tag, " err"},    64'(err),  64'(eerr));
      chk({tag, " mcnt"},   64'(mc),   act ? 64'(bq[bi].m) : 64'd0);
      chk({tag, " kcnt"},   64'(kc),   act ? 64'(bq[bi].k) : 64'd0);
      chk({tag, " ncnt"},   64'(nc),   act ? 64'(bq[bi].n) : 64'd0);
      if (pend) begin
        chk({tag, " rm"}, 64'(rm), 64'(pm));
        chk({tag, " rn"}, 64'(rn), 64'(pn));
      end
`ifdef GEMM_CTRL_PERF_CNT_EN
      if (c > 0 && good) begin
        chk({tag, " cyccnt"},   64'(cyc_cnt),   64'(ecyc));
        chk({tag, " stallcnt"}, 64'(stall_cnt), 64'(estall));
      end
`endif
      // advance the model by one clock
      beat   = iv && e_ir;
      taken  = pend && rr;
      eerr_n = 1'b0;
      if (phase == 0) begin
        if (c == 0) begin
          if (good) begin
            build_order(m_s, k_s, n_s, md);
            total = bq.size();
            phase = 1; bi = 0; ecyc = 0; estall = 0;
          end else begin
            eerr_n = 1'b1;
          end
        end
      end else if (phase == 1) begin
        ecyc++;
        if (act && iv && !e_ir) estall++;
        if (bi == total) begin
          if (taken) begin pend = 0; phase = 2; end
        end else begin
          if (taken) pend = 0;
          if (beat) begin
            if (bq[bi].k == k_s - 1) begin pend = 1; pm = bq[bi].m; pn = bq[bi].n; end
            bi++;
          end
        end
      end else begin
        phase = 0;
      end
      eerr = eerr_n;
      next_cycle();
      if (c > 0 && phase == 0 && !eerr) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      n_vec++;
      n_err++;
      $display("FAIL rand%0d timeout: run not finished after %0d cycles, required done", r, LIMIT);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      next_cycle();
    end
  endtask

  initial begin
    //            mode cyc busy ir ac rv rm rn done mc kc nc
    tbl[0]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 2,  1, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{0, 4,  1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{0, 7,  1, 1, 1, 1, 0, 1, 0, 1, 0, 0};
    tbl[5]  = '{0, 10, 1, 1, 1, 1, 1, 0, 0, 1, 0, 1};
    tbl[6]  = '{0, 12, 1, 1, 0, 0, 0, 0, 0, 1, 2, 1};
    tbl[7]  = '{0, 13, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 14, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 1,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 4,  1, 1, 1, 1, 0, 0, 0, 1, 0, 0};
    tbl[13] = '{1, 7,  1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    tbl[14] = '{1, 10, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1};
    tbl[15] = '{1, 13, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    tbl[16] = '{1, 14, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
`ifdef GEMM_CTRL_PERF_CNT_EN
    chk("reset cyccnt",   64'(cyc_cnt),   64'd0);
    chk("reset stallcnt", 64'(stall_cnt), 64'd0);
`endif
    rst = 1'b0;
    next_cycle();

    // Table-driven 2x3x2 runs in both loop orders.
    for (int md = 0; md < 2; md++) begin
      for (int c = 0; c < 16; c++) begin
        drive(c == 0, 1'(md), 2, 3, 2, 1'b1, 1'b1);
        @(negedge clk);
        for (int t = 0; t < NT; t++) begin
          if (tbl[t].mode == md && tbl[t].cyc == c) begin
            string tag;
            tag = $sformatf("tbl mode%0d c%0d", md, c);
            chk({tag, " busy"},   64'(busy), 64'(tbl[t].busy));
            chk({tag, " ready"},  64'(ir),   64'(tbl[t].ir));
            chk({tag, " aclr"},   64'(ac),   64'(tbl[t].ac));
            chk({tag, " rvalid"}, 64'(rv),   64'(tbl[t].rv));
            chk({tag, " done"},   64'(done), 64'(tbl[t].done));
            chk({tag, " mcnt"},   64'(mc),   64'(tbl[t].mc));
            chk({tag, " kcnt"},   64'(kc),   64'(tbl[t].kc));
            chk({tag, " ncnt"},   64'(nc),   64'(tbl[t].nc));
            if (tbl[t].rv != 0) begin
              chk({tag, " rm"}, 64'(rm), 64'(tbl[t].rm));
              chk({tag, " rn"}, 64'(rn), 64'(tbl[t].rn));
            end
          end
        end
        next_cycle();
      end
    end

    // Result backpressure for 5 cycles; a start with other sizes mid-run is ignored.
    for (int c = 0; c < 21; c++) begin
      if (c == 5) drive(1'b1, 1'b1, 1, 1, 1, 1'b1, 1'b0);
      else drive(c == 0, 1'b0, 2, 3, 2, 1'b1, !(c >= 4 && c <= 8));
      @(negedge clk);
      if (c >= 4 && c <= 8) begin
        chk($sformatf("stall c%0d ready", c),  64'(ir), 64'd0);
        chk($sformatf("stall c%0d rvalid", c), 64'(rv), 64'd1);
        chk($sformatf("stall c%0d rm", c),     64'(rm), 64'd0);
        chk($sformatf("stall c%0d rn", c),     64'(rn), 64'd0);
        chk($sformatf("stall c%0d kcnt", c),   64'(kc), 64'd0);
        chk($sformatf("stall c%0d ncnt", c),   64'(nc), 64'd1);
      end
      if (c == 9)  chk("stall c9 ready", 64'(ir), 64'd1);
      if (c == 12) begin
        chk("stall c12 rvalid", 64'(rv), 64'd1);
        chk("stall c12 rn",     64'(rn), 64'd1);
      end
      if (c == 18) begin
        chk("stall c18 busy", 64'(busy), 64'd1);
        chk("stall c18 done", 64'(done), 64'd0);
        chk("stall c18 rm",   64'(rm),   64'd1);
      end
      if (c == 19) chk("stall c19 done", 64'(done), 64'd1);
`ifdef GEMM_CTRL_PERF_CNT_EN
      if (c == 20) begin
        chk("stall cyccnt",   64'(cyc_cnt),   64'd18);
        chk("stall stallcnt", 64'(stall_cnt), 64'd5);
      end
`endif
      next_cycle();
    end

    // Zero K size: one-cycle error pulse, no run.
    for (int c = 0; c < 3; c++) begin
      drive(c == 0, 1'b0, 2, 0, 2, 1'b1, 1'b1);
      @(negedge clk);
      chk($sformatf("zsize c%0d err", c),  64'(err),  64'(c == 1));
      chk($sformatf("zsize c%0d busy", c), 64'(busy), 64'd0);
      next_cycle();
    end

    // 1x1x1: single beat, single result, done three cycles after start.
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, 1'b0, 1, 1, 1, 1'b1, 1'b1);
      @(negedge clk);
      if (c == 1) begin
        chk("one c1 aclr",  64'(ac),   64'd1);
        chk("one c1 ready", 64'(ir),   64'd1);
      end
      if (c == 2) begin
        chk("one c2 rvalid", 64'(rv), 64'd1);
        chk("one c2 ready",  64'(ir), 64'd0);
        chk("one c2 rm",     64'(rm), 64'd0);
        chk("one c2 rn",     64'(rn), 64'd0);
      end
      chk($sformatf("one c%0d done", c), 64'(done), 64'(c == 3));
      next_cycle();
    end

    // Reset while a result is pending, then a fresh 1x2x1 run.
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, 1'b0, 2, 3, 2, 1'b1, c < 4);
      @(negedge clk);
      if (c == 6) chk("rst pending rvalid", 64'(rv), 64'd1);
      if (c < 6) next_cycle();
    end
    rst = 1'b1;
    #1;
    check_quiet("rst async");
    next_cycle();
    rst = 1'b0;
    next_cycle();
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 1'b0, 1, 2, 1, 1'b1, 1'b1);
      @(negedge clk);
      if (c == 1) chk("after rst c1 aclr", 64'(ac), 64'd1);
      if (c == 2) begin
        chk("after rst c2 kcnt", 64'(kc), 64'd1);
        chk("after rst c2 aclr", 64'(ac), 64'd0);
      end
      if (c == 3) begin
        chk("after rst c3 rvalid", 64'(rv), 64'd1);
        chk("after rst c3 rm",     64'(rm), 64'd0);
        chk("after rst c3 rn",     64'(rn), 64'd0);
      end
      chk($sformatf("after rst c%0d done", c), 64'(done), 64'(c == 4));
      next_cycle();
    end

    // Randomized runs against the loop-order model.
    for (int r = 0; r < NRUNS; r++) rand_run(r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
